// File: rtl/three_phase_sd_decoder.sv
// Three-phase bitstream decoder: third-order CIC decimator per phase.
// Optional ZERO_CROSS_EN adds period and phase-order monitoring of A.
module three_phase_sd_decoder #(
  parameter int DEC_LOG2 = 6,
  parameter int OUT_BW   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              bsA,
  input  logic              bsB,
  input  logic              bsC,
  output logic [OUT_BW-1:0] sampleA,
  output logic [OUT_BW-1:0] sampleB,
  output logic [OUT_BW-1:0] sampleC,
  output logic              sample_valid,
  output logic              settled
`ifdef ZERO_CROSS_EN
  ,
  output logic [15:0]       period,
  output logic              period_valid,
  output logic              seq_err
`endif
);

  localparam int ACC_BW = 3*DEC_LOG2 + 2;
  localparam int SHIFT  = 3*DEC_LOG2 - OUT_BW + 1;

  typedef logic signed [ACC_BW-1:0] acc_t;

  localparam acc_t POS = acc_t'(1) << (OUT_BW-1);
  localparam logic [OUT_BW-1:0] MAXP =
    {1'b0, {(OUT_BW-1){1'b1}}};

  logic [2:0]          bs;
  logic [DEC_LOG2-1:0] dec_cnt;
  logic [1:0]          settled_cnt;
  logic                tick;

  acc_t i1 [3];
  acc_t i2 [3];
  acc_t i3 [3];
  acc_t d1 [3];
  acc_t d2 [3];
  acc_t d3 [3];
  acc_t x  [3];
  acc_t c1 [3];
  acc_t c2 [3];
  acc_t c3 [3];
  acc_t y  [3];

  logic [OUT_BW-1:0] q   [3];
  logic [OUT_BW-1:0] smp [3];

  assign bs      = {bsC, bsB, bsA};
  assign tick    = &dec_cnt;
  assign sampleA = smp[0];
  assign sampleB = smp[1];
  assign sampleC = smp[2];

  // Only +R^3 overflows the signed output range after scaling.
  always_comb begin
    for (int p = 0; p < 3; p++) begin
      x[p]  = bs[p] ? acc_t'(1) : '1;
      c1[p] = i3[p] - d1[p];
      c2[p] = c1[p] - d2[p];
      c3[p] = c2[p] - d3[p];
      y[p]  = c3[p] >>> SHIFT;
      q[p]  = y[p][OUT_BW-1:0];
      if (y[p] == POS) begin
        q[p] = MAXP;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dec_cnt      <= '0;
      settled_cnt  <= '0;
      settled      <= 1'b0;
      sample_valid <= 1'b0;
      for (int p = 0; p < 3; p++) begin
        i1[p]  <= '0;
        i2[p]  <= '0;
        i3[p]  <= '0;
        d1[p]  <= '0;
        d2[p]  <= '0;
        d3[p]  <= '0;
        smp[p] <= '0;
      end
    end else begin
      dec_cnt      <= dec_cnt + 1'b1;
      sample_valid <= tick;
      for (int p = 0; p < 3; p++) begin
        i1[p] <= i1[p] + x[p];
        i2[p] <= i2[p] + i1[p];
        i3[p] <= i3[p] + i2[p];
      end
      if (tick) begin
        for (int p = 0; p < 3; p++) begin
          d1[p]  <= i3[p];
          d2[p]  <= c1[p];
          d3[p]  <= c2[p];
          smp[p] <= q[p];
        end
        if (!settled) begin
          settled_cnt <= settled_cnt + 2'd1;
          if (settled_cnt == 2'd3) begin
            settled <= 1'b1;
          end
        end
      end
    end
  end

`ifdef ZERO_CROSS_EN
  logic [2:0]  rise;
  logic        eval;
  logic        seen_a;
  logic        armed;
  logic [15:0] pcnt;

  // Compare the sample about to be registered with the one on the outputs.
  always_comb begin
    eval = tick & (settled | (settled_cnt == 2'd3));
    for (int p = 0; p < 3; p++) begin
      rise[p] = smp[p][OUT_BW-1] & ~q[p][OUT_BW-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period       <= '0;
      period_valid <= 1'b0;
      seq_err      <= 1'b0;
      seen_a       <= 1'b0;
      armed        <= 1'b0;
      pcnt         <= '0;
    end else begin
      period_valid <= 1'b0;
      if (eval) begin
        if (rise[0]) begin
          pcnt   <= '0;
          seen_a <= 1'b1;
          armed  <= 1'b1;
          if (seen_a) begin
            period       <= (&pcnt) ? pcnt : pcnt + 16'd1;
            period_valid <= 1'b1;
          end
        end else begin
          if (!(&pcnt)) begin
            pcnt <= pcnt + 16'd1;
          end
          if (armed && rise[1]) begin
            armed <= 1'b0;
          end else if (armed && rise[2]) begin
            seq_err <= 1'b1;
          end
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_three_phase_sd_decoder.sv
// Bench for three_phase_sd_decoder: table vectors, corner sequences and
// random bitstreams against a direct CIC impulse-response convolution model.
module tb_three_phase_sd_decoder;

  localparam int DL  = 6;
  localparam int OBW = 16;
  localparam int R   = 1 << DL;
  localparam int KL  = 3*R - 2;
  localparam int SH  = 3*DL - OBW + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic bsA = 1'b0;
  logic bsB = 1'b0;
  logic bsC = 1'b0;
  logic [OBW-1:0] sampleA;
  logic [OBW-1:0] sampleB;
  logic [OBW-1:0] sampleC;
  logic sample_valid;
  logic settled;
`ifdef ZERO_CROSS_EN
  logic [15:0] period;
  logic period_valid;
  logic seq_err;
`endif

  three_phase_sd_decoder #(.DEC_LOG2(DL), .OUT_BW(OBW)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bsA(bsA),
    .bsB(bsB),
    .bsC(bsC),
    .sampleA(sampleA),
    .sampleB(sampleB),
    .sampleC(sampleC),
    .sample_valid(sample_valid),
    .settled(settled)
`ifdef ZERO_CROSS_EN
    ,
    .period(period),
    .period_valid(period_valid),
    .seq_err(seq_err)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  typedef struct {
    logic [3:0] pa;
    logic [3:0] pb;
    logic [3:0] pc;
    int ea;
    int eb;
    int ec;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;
  int h [KL];
  int xh [3][256];
  int n_cyc = 0;
  int n_tick = 0;
  int exp_s [3];
  logic exp_v;

  task automatic chk(input string name,
                     input logic signed [31:0] act,
                     input logic signed [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  // Input history before reset release counts as zero (empty integrators).
  function automatic int xin(int p, int k);
    if (k < 1) return 0;
    return xh[p][k % 256];
  endfunction

  // Tick output = impulse response (three R-boxcars) convolved with x,
  // delayed 3 cycles by the integrator registers.
  function automatic int model_sample(int p);
    int c3;
    int y;
    c3 = 0;
    for (int j = 0; j < KL; j++) c3 += h[j] * xin(p, n_cyc - 3 - j);
    y = c3 >>> SH;
    if (y == (1 << (OBW-1))) y = (1 << (OBW-1)) - 1;
    return y;
  endfunction

  function automatic logic ph(int n);
    return (n % 1280) < 640;
  endfunction

  task automatic cyc(input logic a, input logic b, input logic c);
    bsA = a;
    bsB = b;
    bsC = c;
    @(posedge clk);
    n_cyc++;
    xh[0][n_cyc % 256] = a ? 1 : -1;
    xh[1][n_cyc % 256] = b ? 1 : -1;
    xh[2][n_cyc % 256] = c ? 1 : -1;
    exp_v = (n_cyc % R) == 0;
    if (exp_v) begin
      n_tick++;
      for (int p = 0; p < 3; p++) exp_s[p] = model_sample(p);
    end
    @(negedge clk);
    chk("valid", sample_valid, exp_v);
    chk("settled", settled, n_tick >= 4);
    if (exp_v) begin
      chk("sampleA", $signed(sampleA), exp_s[0]);
      chk("sampleB", $signed(sampleB), exp_s[1]);
      chk("sampleC", $signed(sampleC), exp_s[2]);
    end
  endtask

  task automatic model_clear();
    n_cyc = 0;
    n_tick = 0;
    for (int p = 0; p < 3; p++) exp_s[p] = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_sampleA", $signed(sampleA), 0);
    chk("rst_sampleB", $signed(sampleB), 0);
    chk("rst_sampleC", $signed(sampleC), 0);
    chk("rst_valid", sample_valid, 0);
    chk("rst_settled", settled, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    model_clear();
  endtask

  vec_t vt [4];
  int first;
  int da, db, dc;
  int pulses;

  initial begin
    for (int a = 0; a < R; a++)
      for (int b = 0; b < R; b++)
        for (int c = 0; c < R; c++)
          h[a+b+c] += 1;

    vt[0] = '{4'b1111, 4'b0000, 4'b0101, 32767, -32768, 0};
    vt[1] = '{4'b0111, 4'b0001, 4'b0011, 16384, -16384, 0};
    vt[2] = '{4'b0101, 4'b1111, 4'b1110, 0, 32767, 16384};
    vt[3] = '{4'b1000, 4'b1011, 4'b0000, -16384, 16384, -32768};

    for (int v = 0; v < 4; v++) begin
      do_reset();
      for (int i = 0; i < 6*R; i++)
        cyc(vt[v].pa[i%4], vt[v].pb[i%4], vt[v].pc[i%4]);
      chk("tbl_sampleA", $signed(sampleA), vt[v].ea);
      chk("tbl_sampleB", $signed(sampleB), vt[v].eb);
      chk("tbl_sampleC", $signed(sampleC), vt[v].ec);
    end

    // Asynchronous reset in the middle of a clock-high phase.
    do_reset();
    for (int i = 0; i < 300; i++) cyc(1'b1, 1'b0, 1'(i % 2));
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_sampleA", $signed(sampleA), 0);
    chk("mid_valid", sample_valid, 0);
    chk("mid_settled", settled, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    first = 0;
    for (int i = 1; i <= 100; i++) begin
      cyc(1'b1, 1'b0, 1'(i % 2));
      if (sample_valid && first == 0) first = i;
    end
    chk("first_valid_cycle", first, R);
    for (int i = 0; i < 4*R; i++) cyc(1'b1, 1'b0, 1'(i % 2));
    chk("post_rst_settled", settled, 1);

    do_reset();
    for (int blk = 0; blk < 20; blk++) begin
      da = $urandom_range(0, R);
      db = $urandom_range(0, R);
      dc = $urandom_range(0, R);
      for (int i = 0; i < R; i++)
        cyc($urandom_range(0, R-1) < da,
            $urandom_range(0, R-1) < db,
            $urandom_range(0, R-1) < dc);
    end

    // Long constant run: integrators wrap many times.
    do_reset();
    for (int i = 0; i < 10240; i++) cyc(1'b1, 1'b0, 1'($urandom_range(0, 1)));
    chk("wrap_sampleA", $signed(sampleA), 32767);
    chk("wrap_sampleB", $signed(sampleB), -32768);
    chk("wrap_settled", settled, 1);

`ifdef ZERO_CROSS_EN
    for (int sw = 0; sw < 2; sw++) begin
      do_reset();
      pulses = 0;
      for (int i = 0; i < 6400; i++) begin
        if (sw == 0) cyc(ph(i), ph(i + 1280 - 427), ph(i + 1280 - 853));
        else         cyc(ph(i), ph(i + 1280 - 853), ph(i + 1280 - 427));
        if (period_valid) begin
          pulses++;
          chk("zc_period", period, 20);
        end
      end
      chk("zc_pulses", pulses >= 2, 1);
      chk("zc_seq_err", seq_err, sw);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
